// File: rtl/sccb_master_if.sv
// Request/completion handshake between the camera controller and the SCCB write master.
interface sccb_master_if;
   logic       start;
   logic [7:0] dev_addr;
   logic [7:0] reg_addr;
   logic [7:0] reg_data;
   logic       busy;
   logic       done;
   logic [2:0] ack;

   modport master (output start, dev_addr, reg_addr, reg_data,
                   input  busy, done, ack);
   modport slave  (input  start, dev_addr, reg_addr, reg_data,
                   output busy, done, ack);
endinterface

// File: rtl/sccb_master.sv
// Three-phase SCCB write master: serialises {ID, sub-address, data} onto scl/sda
// using a quarter-bit timebase, and reports the sampled 9th-bit levels.
module sccb_master #(
   parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
   parameter int unsigned SCCB_FREQ_HZ = 100_000
) (
   input  logic         clk,
   input  logic         reset_n,
   sccb_master_if.slave req,
   inout  wire          sda,
   output logic         scl
);
   localparam int unsigned      DIV      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
   localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       quarter;
   logic [4:0]       bit_cnt;
   logic [26:0]      shreg;
   logic [2:0]       ack_shadow;
   logic             sda_low;
   logic             tick;

   assign sda  = sda_low ? 1'b0 : 1'bz;
   assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

   // Quarter-bit timebase; parked at zero while idle so every frame starts aligned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (state == IDLE || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Frame sequencer: each tick loads the bus levels of the quarter that follows,
   // so scl/sda are registered and only move on quarter boundaries.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         quarter    <= 2'd0;
         bit_cnt    <= 5'd0;
         shreg      <= '0;
         ack_shadow <= 3'b000;
         sda_low    <= 1'b0;
         scl        <= 1'b1;
         req.busy   <= 1'b0;
         req.done   <= 1'b0;
         req.ack    <= 3'b000;
      end else begin
         req.done <= 1'b0;
         case (state)
            IDLE: begin
               if (req.start) begin
                  shreg    <= {req.dev_addr, 1'b1, req.reg_addr, 1'b1, req.reg_data, 1'b1};
                  state    <= START;
                  quarter  <= 2'd0;
                  bit_cnt  <= 5'd0;
                  req.busy <= 1'b1;
                  sda_low  <= 1'b1;
                  scl      <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (quarter == 2'd0) begin
                     quarter <= 2'd1;
                     scl     <= 1'b0;
                  end else begin
                     state   <= BIT;
                     quarter <= 2'd0;
                     sda_low <= ~shreg[26];
                  end
               end
            end
            BIT: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: scl <= 1'b1;
                     2'd1: scl <= 1'b1;
                     2'd2: begin
                        scl <= 1'b0;
                        // The slot after each byte is released, so this is the slave's level.
                        case (bit_cnt)
                           5'd8:    ack_shadow[2] <= sda;
                           5'd17:   ack_shadow[1] <= sda;
                           5'd26:   ack_shadow[0] <= sda;
                           default: ;
                        endcase
                     end
                     default: begin
                        shreg <= {shreg[25:0], 1'b0};
                        if (bit_cnt == 5'd26) begin
                           state   <= STOP;
                           quarter <= 2'd0;
                           sda_low <= 1'b1;
                        end else begin
                           bit_cnt <= bit_cnt + 5'd1;
                           sda_low <= ~shreg[25];
                        end
                     end
                  endcase
               end
            end
            STOP: begin
               if (tick) begin
                  case (quarter)
                     2'd0: begin
                        quarter <= 2'd1;
                        scl     <= 1'b1;
                     end
                     2'd1: begin
                        quarter <= 2'd2;
                        sda_low <= 1'b0;
                     end
                     default: begin
                        state    <= IDLE;
                        quarter  <= 2'd0;
                        req.busy <= 1'b0;
                        req.done <= 1'b1;
                        req.ack  <= ack_shadow;
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: an SCCB slave monitor decodes frames against a byte scoreboard,
// plus timing checks on a default instance and a fast (DIV=4) instance.
`timescale 1ns/1ps
module tb_sccb_master;
   localparam int unsigned DIV_A = 62;
   localparam int unsigned DIV_B = 4;
   localparam int unsigned TXN_A = 113 * DIV_A;
   localparam int unsigned TXN_B = 113 * DIV_B;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   sccb_master_if bus_a();
   sccb_master_if bus_b();
   wire  sda_a;
   wire  sda_b;
   logic scl_a;
   logic scl_b;
   logic slave_pull = 1'b0;
   logic [2:0] ack_mask = 3'b000;

   pullup pu_a (sda_a);
   pullup pu_b (sda_b);
   assign sda_a = slave_pull ? 1'b0 : 1'bz;

   sccb_master u_dut_a (
      .clk(clk), .reset_n(reset_n), .req(bus_a), .sda(sda_a), .scl(scl_a)
   );

   sccb_master #(.CLK_FREQ_HZ(1_600_000), .SCCB_FREQ_HZ(100_000)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .req(bus_b), .sda(sda_b), .scl(scl_b)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_bytes [$];
   logic [2:0] exp_acks  [$];
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int unsigned actual, input int unsigned expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Slave monitor on bus A: decodes bits on scl falling edges and acknowledges per ack_mask.
   logic       mon_prev_scl = 1'b1;
   logic       mon_prev_sda = 1'b1;
   logic       mon_in_frame = 1'b0;
   logic       mon_armed    = 1'b0;
   int         mon_bitn     = 0;
   int         mon_nbytes   = 0;
   logic [7:0] mon_byte     = 8'h00;
   int unsigned done_count  = 0;
   int unsigned busy_total  = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         mon_in_frame = 1'b0;
         mon_armed    = 1'b0;
         mon_bitn     = 0;
         mon_nbytes   = 0;
         slave_pull   = 1'b0;
         mon_prev_scl = 1'b1;
         mon_prev_sda = 1'b1;
      end else begin
         if (mon_prev_scl && scl_a && mon_prev_sda && !sda_a) begin
            check("start_outside_frame", mon_in_frame, 0);
            mon_in_frame = 1'b1;
            mon_armed    = 1'b0;
            mon_bitn     = 0;
            mon_nbytes   = 0;
         end else if (mon_prev_scl && scl_a && !mon_prev_sda && sda_a) begin
            check("stop_byte_count", mon_nbytes, 3);
            check("stop_bit_align", mon_bitn, 0);
            mon_in_frame = 1'b0;
            slave_pull   = 1'b0;
         end else if (mon_prev_scl && !scl_a && mon_in_frame) begin
            if (!mon_armed) begin
               mon_armed = 1'b1;
            end else if (mon_bitn < 8) begin
               mon_byte = {mon_byte[6:0], mon_prev_sda};
               mon_bitn++;
               if (mon_bitn == 8 && mon_nbytes < 3) slave_pull = ack_mask[2 - mon_nbytes];
            end else begin
               check("byte_expected", exp_bytes.size() != 0, 1);
               if (exp_bytes.size() != 0) check("byte_value", mon_byte, exp_bytes.pop_front());
               mon_nbytes++;
               mon_bitn   = 0;
               slave_pull = 1'b0;
            end
         end
         mon_prev_scl = scl_a;
         mon_prev_sda = sda_a;
         if (bus_a.done) begin
            done_count++;
            check("busy_low_in_done", bus_a.busy, 0);
            check("ack_expected", exp_acks.size() != 0, 1);
            if (exp_acks.size() != 0) check("ack_value", bus_a.ack, exp_acks.pop_front());
         end
         if (bus_a.busy) busy_total++;
      end
   end

   // SCL period / high-time tracker on bus B.
   logic        b_prev_scl = 1'b1;
   int unsigned b_rises = 0, b_last_rise = 0;
   int unsigned b_per_min = 1000, b_per_max = 0, b_hi_min = 1000, b_hi_max = 0;

   always @(negedge clk) begin
      if (reset_n && bus_b.busy) begin
         if (!b_prev_scl && scl_b) begin
            if (b_rises > 0) begin
               if (cyc - b_last_rise < b_per_min) b_per_min = cyc - b_last_rise;
               if (cyc - b_last_rise > b_per_max) b_per_max = cyc - b_last_rise;
            end
            b_rises++;
            b_last_rise = cyc;
         end
         if (b_prev_scl && !scl_b && b_rises > 0) begin
            if (cyc - b_last_rise < b_hi_min) b_hi_min = cyc - b_last_rise;
            if (cyc - b_last_rise > b_hi_max) b_hi_max = cyc - b_last_rise;
         end
      end
      b_prev_scl = scl_b;
   end

   int unsigned start_edge, snap_busy, snap_done;

   task automatic applyStimulus(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] rd,
                                input logic [2:0] mask, input bit hold);
      @(negedge clk);
      snap_busy      = busy_total;
      snap_done      = done_count;
      ack_mask       = mask;
      bus_a.dev_addr = dev;
      bus_a.reg_addr = ra;
      bus_a.reg_data = rd;
      bus_a.start    = 1'b1;
      exp_bytes.push_back(dev);
      exp_bytes.push_back(ra);
      exp_bytes.push_back(rd);
      exp_acks.push_back(~mask);
      @(posedge clk);
      #1;
      start_edge = cyc;
      if (!hold) bus_a.start = 1'b0;
      check("busy_after_start", bus_a.busy, 1);
   endtask

   task automatic waitDone(input string name, input int unsigned limit, input bit use_b,
                           output int unsigned done_edge);
      bit seen;
      seen      = 1'b0;
      done_edge = 0;
      for (int i = 0; i < int'(limit) && !seen; i++) begin
         @(negedge clk);
         if (use_b ? bus_b.done : bus_a.done) begin
            seen      = 1'b1;
            done_edge = cyc;
         end
      end
      check({name, "_done_seen"}, seen, 1);
   endtask

   task automatic checkOutput(input string name);
      int unsigned d;
      waitDone(name, TXN_A + 100, 1'b0, d);
      check({name, "_latency"}, d - start_edge, TXN_A);
      repeat (2) @(negedge clk);
      check({name, "_busy_cycles"}, busy_total - snap_busy, TXN_A);
      check({name, "_done_pulses"}, done_count - snap_done, 1);
      check({name, "_bytes_left"}, exp_bytes.size(), 0);
      check({name, "_acks_left"}, exp_acks.size(), 0);
   endtask

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ra;
      logic [7:0] rd;
      logic [2:0] mask;
      string      name;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int unsigned d1, d2, sb, db;

      vecs[0] = '{dev: 8'h42, ra: 8'h12, rd: 8'h80, mask: 3'b111, name: "v0_acked"};
      vecs[1] = '{dev: 8'h42, ra: 8'h12, rd: 8'h80, mask: 3'b000, name: "v1_floating"};
      vecs[2] = '{dev: 8'h42, ra: 8'hAA, rd: 8'h55, mask: 3'b101, name: "v2_mixed"};
      vecs[3] = '{dev: 8'h42, ra: 8'h00, rd: 8'hFF, mask: 3'b001, name: "v3_mixed"};

      bus_a.start = 1'b0; bus_a.dev_addr = 8'h00; bus_a.reg_addr = 8'h00; bus_a.reg_data = 8'h00;
      bus_b.start = 1'b0; bus_b.dev_addr = 8'h00; bus_b.reg_addr = 8'h00; bus_b.reg_data = 8'h00;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_scl", scl_a, 1);
      check("reset_sda", sda_a, 1);
      check("reset_busy", bus_a.busy, 0);
      check("reset_done", bus_a.done, 0);
      check("reset_ack", bus_a.ack, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].dev, vecs[i].ra, vecs[i].rd, vecs[i].mask, 1'b0);
         checkOutput(vecs[i].name);
      end

      // Start pulses with different bytes while busy must be ignored.
      applyStimulus(8'h42, 8'h3A, 8'h04, 3'b011, 1'b0);
      for (int k = 0; k < 10; k++) begin
         repeat (500) @(negedge clk);
         bus_a.dev_addr = 8'h00; bus_a.reg_addr = 8'hFF; bus_a.reg_data = 8'h11;
         bus_a.start    = 1'b1;
         @(negedge clk);
         bus_a.start    = 1'b0;
      end
      checkOutput("pulse");
      repeat (300) @(negedge clk);
      check("pulse_no_extra_done", done_count - snap_done, 1);
      check("pulse_idle_after", bus_a.busy, 0);

      // Start held through done: the second frame takes the bytes present at that moment.
      applyStimulus(8'h42, 8'h40, 8'hD0, 3'b110, 1'b1);
      repeat (1000) @(negedge clk);
      bus_a.reg_addr = 8'h8C; bus_a.reg_data = 8'h02;
      exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h8C); exp_bytes.push_back(8'h02);
      exp_acks.push_back(3'b001);
      waitDone("held_first", TXN_A + 100, 1'b0, d1);
      check("held_first_latency", d1 - start_edge, TXN_A);
      @(negedge clk);
      check("held_busy_next_cycle", bus_a.busy, 1);
      bus_a.start = 1'b0;
      waitDone("held_second", TXN_A + 100, 1'b0, d2);
      check("held_second_latency", d2 - d1, TXN_A + 1);
      repeat (2) @(negedge clk);
      check("held_done_pulses", done_count - snap_done, 2);
      check("held_bytes_left", exp_bytes.size(), 0);

      // Reset during bit 14 aborts the frame without done; a fresh frame then completes.
      applyStimulus(8'h42, 8'h11, 8'h22, 3'b111, 1'b0);
      repeat (60 * DIV_A + 30) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_scl", scl_a, 1);
      check("abort_sda", sda_a, 1);
      check("abort_busy", bus_a.busy, 0);
      check("abort_done", bus_a.done, 0);
      repeat (20) @(negedge clk);
      exp_bytes.delete();
      exp_acks.delete();
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      check("abort_no_done", done_count - snap_done, 0);
      check("abort_ack_reset", bus_a.ack, 0);
      applyStimulus(8'h42, 8'h6B, 8'h4A, 3'b111, 1'b0);
      checkOutput("after_abort");

      // Fast instance: quarter = 4 clocks.
      @(negedge clk);
      bus_b.dev_addr = 8'h42; bus_b.reg_addr = 8'h12; bus_b.reg_data = 8'h80;
      bus_b.start    = 1'b1;
      @(posedge clk);
      #1;
      sb = cyc;
      bus_b.start = 1'b0;
      waitDone("div4", TXN_B + 50, 1'b1, db);
      check("div4_latency", db - sb, TXN_B);
      check("div4_ack_floating", bus_b.ack, 3'b111);
      check("div4_scl_rises", b_rises, 28);
      check("div4_period_min", b_per_min, 4 * DIV_B);
      check("div4_period_max", b_per_max, 4 * DIV_B);
      check("div4_high_min", b_hi_min, 2 * DIV_B);
      check("div4_high_max", b_hi_max, 2 * DIV_B);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB (I2C-compatible) 3-phase write master that programs OV7670 registers. It sits directly downstream of the camera controller. It accepts one {device ID, sub-address, data} write request at a time and serialises it onto the camera's `scl`/`sda` pins. It reports completion, plus the sampled don't-care/ACK bits for debug. Write-only; OV7670 configuration never reads back.

## Interface
- `CLK_FREQ_HZ`, 25_000_000, frequency of `clk`.
- `SCCB_FREQ_HZ`, 100_000, target SCL frequency. Quarter-bit divisor DIV = CLK_FREQ_HZ / (4*SCCB_FREQ_HZ), integer-truncated, must be ≥1 (default 62).

Ports:
- `clk`  in  1  core clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse/level; sampled only when idle.
- `dev_addr`  in  8  SCCB ID address byte including R/W bit (OV7670 write = 8'h42).
- `reg_addr`  in  8  sub-address byte.
- `reg_data`  in  8  write data byte.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `ack`  out  3  sampled SDA level in the 9th bit of phases {1,2,3} (bit2 = phase 1) of the last completed transaction.
- `sda`  inout  1  open-drain data: drives 0 or high-Z only (external pull-up).
- `scl`  out  1  SCCB clock, push-pull.

## Operation
- Reset values: `scl`=1, `sda`=Z, `busy`=0, `done`=0, `ack`=3'b000, state IDLE, divider 0.
- Divider counts 0..DIV-1 and emits a quarter-tick when it reaches DIV-1. It is held at 0 in IDLE. All state/phase advances happen on quarter-ticks.
- IDLE: `scl`=1, `sda`=Z. When `start`=1, latch the three bytes into a 27-bit shift register as {dev_addr,1'b1,reg_addr,1'b1,reg_data,1'b1}, where the 1 means "release". Then go to START.
- START, 2 quarters: q0 `sda`=0, `scl`=1; q1 `sda`=0, `scl`=0.
- BIT, 27 bits × 4 quarters, MSB first:
  - q0 `scl`=0, `sda` set to the shift-register MSB (0 → drive 0, 1 → Z).
  - q1, q2 `scl`=1.
  - q3 `scl`=0.
  - On the 9th bit of each phase, `sda` is Z and the raw `sda` pin is sampled at the q2 tick into an internal ack shadow.
  - Shift after q3. Bit counter 0..26; after bit 26 go to STOP.
- STOP, 3 quarters: q0 `sda`=0, `scl`=0; q1 `sda`=0, `scl`=1; q2 `sda`=Z, `scl`=1. Then go to IDLE.
- On entry to IDLE from STOP: `done`=1 for exactly one cycle, `busy`=0 in that same cycle, and `ack` is updated from the shadow.
- `start` while `busy`=1: ignored, with no queueing and no latch of new bytes. `start` in the `done` cycle is accepted, because busy=0.
- Don't-care bits never affect sequencing; `ack`=1 is not an error.
- Reset mid-transaction: outputs go to reset values immediately (asynchronous), with no `done`. The bus may see an aborted frame, and the upstream controller must re-issue the request.

## Timing
- `start` sampled high at edge N → `busy`=1 from N+1. The first quarter (START q0, `sda` falls with `scl` high) is driven from N+1.
- Total transaction = 2+108+3 = 113 quarters = 113·DIV cycles. `done` is high in cycle N+1+113·DIV. Default: 7006 cycles, about 280 µs at 25 MHz.
- `scl`/`sda` are registered outputs, changing only on quarter-tick boundaries. `sda` never changes while `scl`=1 except at the START and STOP edges.
- SCL period = 4·DIV cycles (default 248 cycles ≈ 100.8 kHz). High time = 2·DIV.
- `ack` is stable between `done` pulses.

## Test plan
- Reset: hold `reset_n`=0 → `scl`=1, `sda`=Z, `busy`=0, `done`=0, `ack`=000.
- Single write, default params, dev 8'h42, reg 8'h12, data 8'h80:
  - the bench's SCCB slave model decodes bytes 42/12/80 in order with a valid START and STOP;
  - `busy` lasts 7006 cycles;
  - `done` pulses once at N+7007.
- Slave model pulls SDA low in every 9th bit → `ack`=000. Leaving SDA floating → `ack`=111. Byte timing is identical in both cases.
- Pulse `start` repeatedly mid-transaction → ignored; the transaction bytes are unchanged. `start` held high through the `done` cycle → a second transaction begins with busy high on the next cycle.
- Deassert `reset_n` during bit 14 → `scl`=1, `sda`=Z immediately, no `done`. A fresh `start` afterwards produces a complete, correct frame.
- CLK_FREQ_HZ=1_600_000, SCCB_FREQ_HZ=100_000 (DIV=4) → SCL period 16 cycles, transaction 452 cycles, `done` at N+453.
